// File: rtl/dat_read_ser.sv
// SD DAT0 block receiver: start bit, 8*len data bits (MSB first), CRC16, end bit.
// Optional WAIT_START timeout is compiled in with `define SDHCI_DAT_READ_TIMEOUT_EN.
module dat_read_ser #(
  parameter logic [15:0] TimeoutTicks = 16'd1000,
  parameter int          MaxLenW      = 12
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               sd_clk_en_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [MaxLenW-1:0] block_len_i,
  input  logic               dat_ser_i,
  output logic               shift_in_o,
  input  logic [15:0]        crc16_i,
  output logic [7:0]         data_o,
  output logic               data_valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               crc_err_o,
  output logic               end_err_o,
  output logic               timeout_err_o
);

  localparam int CntW = MaxLenW + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    DATA,
    CRC,
    END,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CntW-1:0] len_q;
  logic [CntW-1:0] byte_cnt;
  logic [2:0]      bit_cnt;
  logic [3:0]      crc_cnt;
  logic [7:0]      shreg;
  logic [7:0]      data_q;
  logic            data_valid_q;
  logic [15:0]     crc_exp;
  logic [15:0]     crc_rx;
  logic            crc_err_q;
  logic            end_err_q;
  logic            last_byte;
  logic            tmo_hit;

  assign last_byte = (byte_cnt + CntW'(1)) == len_q;

`ifdef SDHCI_DAT_READ_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_err_q;

  assign tmo_hit       = (tmo_cnt == TimeoutTicks - 16'd1);
  assign timeout_err_o = tmo_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt   <= 16'd0;
      tmo_err_q <= 1'b0;
    end else if (!abort_i) begin
      if (state == IDLE && start_i) begin
        tmo_cnt   <= 16'd0;
        tmo_err_q <= 1'b0;
      end else if (state == WAIT_START && sd_clk_en_i && dat_ser_i) begin
        tmo_cnt <= tmo_cnt + 16'd1;
        if (tmo_hit) tmo_err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit       = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       if (start_i) state_nxt = WAIT_START;
        WAIT_START: if (sd_clk_en_i) begin
                      if (!dat_ser_i)   state_nxt = DATA;
                      else if (tmo_hit) state_nxt = DONE;
                    end
        DATA:       if (sd_clk_en_i && bit_cnt == 3'd7 && last_byte) state_nxt = CRC;
        CRC:        if (sd_clk_en_i && crc_cnt == 4'd15) state_nxt = END;
        END:        if (sd_clk_en_i) state_nxt = DONE;
        DONE:       state_nxt = IDLE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: abort freezes everything, so error flags survive it untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q        <= '0;
      byte_cnt     <= '0;
      bit_cnt      <= 3'd0;
      crc_cnt      <= 4'd0;
      shreg        <= 8'h00;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      crc_exp      <= 16'h0000;
      crc_rx       <= 16'h0000;
      crc_err_q    <= 1'b0;
      end_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (!abort_i) begin
        case (state)
          IDLE: if (start_i) begin
            // A zero length field means the full 2^MaxLenW bytes.
            len_q     <= {(block_len_i == '0), block_len_i};
            byte_cnt  <= '0;
            bit_cnt   <= 3'd0;
            crc_cnt   <= 4'd0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
          end
          WAIT_START: if (sd_clk_en_i && !dat_ser_i) begin
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            crc_cnt  <= 4'd0;
          end
          DATA: if (sd_clk_en_i) begin
            shreg   <= {shreg[6:0], dat_ser_i};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_q       <= {shreg[6:0], dat_ser_i};
              data_valid_q <= 1'b1;
              byte_cnt     <= byte_cnt + CntW'(1);
            end
          end
          CRC: if (sd_clk_en_i) begin
            // The CRC engine clears on this tick, so grab its final value now.
            if (crc_cnt == 4'd0) crc_exp <= crc16_i;
            crc_rx  <= {crc_rx[14:0], dat_ser_i};
            crc_cnt <= crc_cnt + 4'd1;
          end
          END: if (sd_clk_en_i) begin
            if (!dat_ser_i)        end_err_q <= 1'b1;
            if (crc_rx != crc_exp) crc_err_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign shift_in_o   = (state == DATA);
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign crc_err_o    = crc_err_q;
  assign end_err_o    = end_err_q;

endmodule

// File: tb/tb_dat_read_ser.sv
// Self-checking bench for dat_read_ser: table of whole blocks plus abort,
// mid-block reset and WAIT_START timeout / no-timeout sequences.
module tb_dat_read_ser;
  localparam int MaxLenW = 12;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sd_en = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [MaxLenW-1:0] block_len = '0;
  logic               dat = 1'b1;
  logic               shift_in;
  logic [15:0]        crc_eng = 16'h0000;
  logic [7:0]         data;
  logic               data_valid, busy, done, crc_err, end_err, tmo_err;

  int checks = 0;
  int errors = 0;
  int div = 1;
  int divcnt = 0;
  int vld_cnt = 0, byte_err = 0, done_cnt = 0;
  int vld_base = 0, cur_mode = 0;

  typedef struct {
    logic [MaxLenW-1:0] len;
    int                 nbytes;
    int                 mode;
    int                 div;
    logic               flip;
    logic               end_bit;
    logic [15:0]        crc_lit;
    logic               exp_crc;
    logic               exp_end;
  } vec_t;

  vec_t vecs[6];

  dat_read_ser #(.TimeoutTicks(16'd1000), .MaxLenW(MaxLenW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sd_clk_en_i(sd_en), .start_i(start),
    .abort_i(abort), .block_len_i(block_len), .dat_ser_i(dat),
    .shift_in_o(shift_in), .crc16_i(crc_eng), .data_o(data),
    .data_valid_o(data_valid), .busy_o(busy), .done_o(done),
    .crc_err_o(crc_err), .end_err_o(end_err), .timeout_err_o(tmo_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (divcnt >= div - 1) begin
      divcnt <= 0;
      sd_en  <= 1'b1;
    end else begin
      divcnt <= divcnt + 1;
      sd_en  <= 1'b0;
    end
  end

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [7:0] pat(input int mode, input int i);
    logic [31:0] iv;
    iv = i;
    case (mode)
      0:       return 8'hFF;
      1:       return 8'hA5;
      default: return iv[7:0] ^ 8'h3C;
    endcase
  endfunction

  // Reference CRC16 engine: accumulates while shifting, clears on any other tick.
  always @(posedge clk) begin
    if (sd_en) crc_eng <= shift_in ? crc_upd(crc_eng, dat) : 16'h0000;
  end

  always @(negedge clk) begin
    if (data_valid) begin
      if (data !== pat(cur_mode, vld_cnt - vld_base)) byte_err++;
      vld_cnt++;
    end
    if (done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_bit(input logic b);
    dat = b;
    do @(negedge clk); while (!sd_en);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int b = 7; b >= 0; b--) tick_bit(v[b]);
  endtask

  task automatic pulse_start(input logic [MaxLenW-1:0] len);
    block_len = len;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] crc;
    logic [7:0]  b;
    int          be0, d0;
    div      = v.div;
    vld_base = vld_cnt;
    cur_mode = v.mode;
    be0      = byte_err;
    d0       = done_cnt;
    pulse_start(v.len);
    tick_bit(1'b1);
    tick_bit(1'b1);
    tick_bit(1'b0);
    crc = 16'h0000;
    for (int i = 0; i < v.nbytes; i++) begin
      b = pat(v.mode, i);
      send_byte(b);
      for (int k = 7; k >= 0; k--) crc = crc_upd(crc, b[k]);
    end
    if (v.crc_lit != 16'h0000) crc = v.crc_lit;
    if (v.flip) crc = crc ^ 16'h0100;
    for (int k = 15; k >= 0; k--) tick_bit(crc[k]);
    tick_bit(v.end_bit);
    dat = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, " valid_count"}, 32'(vld_cnt - vld_base), 32'(v.nbytes));
    chk({tag, " byte_errors"}, 32'(byte_err - be0), 32'd0);
    chk({tag, " done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, " crc_err"}, 32'(crc_err), 32'(v.exp_crc));
    chk({tag, " end_err"}, 32'(end_err), 32'(v.exp_end));
    chk({tag, " timeout_err"}, 32'(tmo_err), 32'd0);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " data_hold"}, 32'(data), 32'(pat(v.mode, v.nbytes - 1)));
  endtask

  initial begin
    vec_t        second;
    logic [7:0]  b;
    int          d0, v0;

    vecs[0] = '{12'd512, 512,  0, 1, 1'b0, 1'b1, 16'h7FA1, 1'b0, 1'b0};
    vecs[1] = '{12'd512, 512,  0, 1, 1'b1, 1'b1, 16'h7FA1, 1'b1, 1'b0};
    vecs[2] = '{12'd512, 512,  0, 1, 1'b0, 1'b0, 16'h7FA1, 1'b0, 1'b1};
    vecs[3] = '{12'd1,   1,    1, 4, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{12'd3,   3,    2, 2, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{12'd0,   4096, 2, 1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    second  = '{12'd2,   2,    2, 1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset data", 32'(data), 32'd0);
    chk("reset misc", 32'({data_valid, shift_in, crc_err, end_err, tmo_err}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort after 100 data ticks, with start raised in the same cycle.
    div = 1; cur_mode = 2; vld_base = vld_cnt; d0 = done_cnt;
    pulse_start(12'd512);
    tick_bit(1'b1);
    tick_bit(1'b0);
    for (int i = 0; i < 100; i++) begin
      b = pat(2, i / 8);
      tick_bit(b[7 - (i % 8)]);
    end
    @(negedge clk) begin abort = 1'b1; start = 1'b1; end
    @(negedge clk) begin abort = 1'b0; start = 1'b0; end
    repeat (2) @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort shift", 32'(shift_in), 32'd0);
    chk("abort done", 32'(done_cnt - d0), 32'd0);
    chk("abort valids", 32'(vld_cnt - vld_base), 32'd12);
    run_vec(second, "after_abort");

    // Reset asserted mid-block.
    cur_mode = 1; vld_base = vld_cnt; d0 = done_cnt;
    pulse_start(12'd4);
    tick_bit(1'b1);
    tick_bit(1'b0);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) tick_bit(1'b0);
    chk("midrst data_before", 32'(data), 32'h000000A5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst data", 32'(data), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    dat = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst idle", 32'(busy), 32'd0);

    // Line held high in WAIT_START.
    div = 1; d0 = done_cnt;
    pulse_start(12'd1);
`ifdef SDHCI_DAT_READ_TIMEOUT_EN
    repeat (999) tick_bit(1'b1);
    chk("tmo early_done", 32'(done_cnt - d0), 32'd0);
    chk("tmo early_busy", 32'(busy), 32'd1);
    tick_bit(1'b1);
    repeat (2) @(negedge clk);
    chk("tmo done", 32'(done_cnt - d0), 32'd1);
    chk("tmo flag", 32'(tmo_err), 32'd1);
    chk("tmo idle", 32'(busy), 32'd0);
`else
    repeat (1100) tick_bit(1'b1);
    chk("wait busy", 32'(busy), 32'd1);
    chk("wait no_done", 32'(done_cnt - d0), 32'd0);
    chk("wait tmo_flag", 32'(tmo_err), 32'd0);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    @(negedge clk);
    chk("wait abort_idle", 32'(busy), 32'd0);
`endif

    v0 = checks;
    if (v0 == 0) $display("FAIL no checks executed: got 0, required >0");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
